alu_iter_unit: RTL and testbench
================================

Name: alu_iter_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALUCon code produced by the ALU control decoder and returns the result plus branch-compare flags.
- Uses a valid/ready handshake on both sides.
- Logic/arithmetic ops complete in one cycle. Shifts are iterative, one bit per cycle, unless the fast shifter is compiled in.
- Sits between the decode/control logic and the writeback/branch-resolution logic.

Parameters:
- XLEN, 32, operand/result width; shift amount is op_b[$clog2(XLEN)-1:0].

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  unit can accept a request this cycle
- alu_con  in  4  ALUCon operation code
- op_a  in  XLEN  operand A
- op_b  in  XLEN  operand B / shift amount
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result
- zero  out  1  result == 0
- lt  out  1  signed op_a < op_b
- ltu  out  1  unsigned op_a < op_b
- busy  out  1  shift iteration in progress

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0: state=IDLE, out_valid=0, result=0, zero=0, lt=0, ltu=0, busy=0, in_ready=0. Reset asserted mid-shift aborts the operation with no output.
- Op codes:
  - 0000 add: a+b
  - 0001 sub: a-b
  - 0010 xor
  - 0011 or
  - 0100 and
  - 0101 sll
  - 0110 srl
  - 0111 sra
  - 1100 compare: result=a-b
  - 1101 slt: result={0..,signed a<b}
  - 1011 sltu: result={0..,unsigned a<b}
  - Any other code: executes as add.
- Arithmetic: modulo 2^XLEN, no overflow output. lt/ltu are computed from the captured operands for every op. zero reflects the final result.
- Handshake:
  - A request transfers on in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Output transfers on out_valid && out_ready.
  - result and flags hold stable while out_valid=1 && out_ready=0.
- States:
  - IDLE: on accept of a non-shift op, compute and go to DONE. On accept of a shift op with shamt>0, load the shift register and counter=shamt, then go to SHIFT. On accept of a shift with shamt=0, go to DONE with result=op_a.
  - SHIFT: busy=1, in_ready=0. Each cycle shift by 1 (sll: zero fill; srl: zero fill; sra: sign fill) and decrement the counter. When the counter reaches 1, the final shift occurs and the state moves to DONE.
  - DONE: out_valid=1.
    - If out_ready=1 and a new request is accepted the same cycle, process it exactly as from IDLE (back-to-back, no bubble).
    - If out_ready=1 with no new request, go to IDLE and drop out_valid.
- Latency from the accepting edge to out_valid:
  - Non-shift op: 1 cycle.
  - Shift with shamt=0: 1 cycle.
  - Shift with shamt>0: shamt+1 cycles.
- Only op_b[$clog2(XLEN)-1:0] is used for shift amount; upper bits are ignored.
- Operands are captured at accept; changes to inputs afterwards have no effect.

Optional Feature:
- Macro ALU_FAST_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter, the SHIFT state is never entered, busy is tied to 0, and every op has 1-cycle latency.
- Undefined: iterative shifter as described under Behaviour.

Test Plan:
- Reset mid-shift: sll with shamt=31 accepted, rst_n pulsed low on cycle 5 -> outputs zeroed immediately, no out_valid after release, next add accepted normally.
- add a=0xFFFFFFFF, b=1 -> result=0x00000000, zero=1, ltu=0, lt=1, out_valid one cycle after accept. Then sub a=5, b=7 -> result=0xFFFFFFFE.
- sra a=0x80000000, b=0x00000024 (shamt=4) -> result=0xF8000000 after 5 cycles, busy high 4 cycles. Then srl on the same operands -> 0x08000000.
- Backpressure: out_ready=0 for 3 cycles after slt a=-1, b=1 -> result=0x00000001 held stable, in_ready=0. Raising out_ready with in_valid high -> new op accepted the same cycle.
- Compare code 1100 with a=b=0x1234 -> zero=1. Undefined code 1111 with a=2, b=3 -> result=5.
- With ALU_FAST_SHIFT_EN defined: sll a=1, b=31 -> result=0x80000000 in 1 cycle, busy never asserts.

Source files
------------

// File: rtl/alu_iter_unit.sv
// Execute-stage ALU driven by the 4-bit ALUCon code, with valid/ready on both sides.
// Shifts iterate one bit per cycle unless ALU_FAST_SHIFT_EN selects a barrel shifter.
module alu_iter_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_con,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt,
  output logic            ltu,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST_SHIFT = 1'b1;
`else
  localparam bit FAST_SHIFT = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shk_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_CMP  = 4'b1100;
  localparam logic [3:0] OP_SLT  = 4'b1101;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  state_e          state_q, state_d;
  shk_e            shk_q, shk_d, shk_in;
  logic [XLEN-1:0] res_q, res_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic            zero_q, zero_d;
  logic            lt_q, lt_d;
  logic            ltu_q, ltu_d;

  logic [SW-1:0]   shamt;
  logic            accept, is_shift, iter_start, lt_in, ltu_in;
  logic [XLEN-1:0] alu_res, shifted;

  function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] v, input shk_e k);
    case (k)
      SH_LL:   return {v[XLEN-2:0], 1'b0};
      SH_RL:   return {1'b0, v[XLEN-1:1]};
      default: return {v[XLEN-1], v[XLEN-1:1]};
    endcase
  endfunction

  assign shamt    = op_b[SW-1:0];
  assign accept   = in_valid && in_ready;
  assign is_shift = (alu_con == OP_SLL) || (alu_con == OP_SRL) || (alu_con == OP_SRA);
  // A zero shift amount finishes like any single-cycle op, so only nonzero shifts iterate.
  assign iter_start = !FAST_SHIFT && is_shift && (shamt != '0);
  assign lt_in    = $signed(op_a) < $signed(op_b);
  assign ltu_in   = op_a < op_b;
  assign shifted  = shift1(res_q, shk_q);

  always_comb begin
    case (alu_con[1:0])
      2'b01:   shk_in = SH_LL;
      2'b10:   shk_in = SH_RL;
      default: shk_in = SH_RA;
    endcase
  end

  // Single-cycle datapath; shifts here only matter for the barrel build or shamt=0.
  always_comb begin
    alu_res = op_a + op_b;
    case (alu_con)
      OP_SUB:  alu_res = op_a - op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_SLL:  alu_res = FAST_SHIFT ? (op_a << shamt) : op_a;
      OP_SRL:  alu_res = FAST_SHIFT ? (op_a >> shamt) : op_a;
      OP_SRA:  alu_res = FAST_SHIFT ? XLEN'($signed(op_a) >>> shamt) : op_a;
      OP_CMP:  alu_res = op_a - op_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_in};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, ltu_in};
      default: alu_res = op_a + op_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shk_q   <= SH_LL;
      res_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      lt_q    <= 1'b0;
      ltu_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shk_q   <= shk_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      lt_q    <= lt_d;
      ltu_q   <= ltu_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shk_d   = shk_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    lt_d    = lt_q;
    ltu_d   = ltu_q;
    case (state_q)
      S_SHIFT: begin
        res_d = shifted;
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_d = S_DONE;
          zero_d  = (shifted == '0);
        end
      end
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: ;
    endcase
    // A new accept (from IDLE or a draining DONE) overrides the hold/idle path.
    if (accept) begin
      lt_d  = lt_in;
      ltu_d = ltu_in;
      if (iter_start) begin
        state_d = S_SHIFT;
        res_d   = op_a;
        cnt_d   = shamt;
        shk_d   = shk_in;
        zero_d  = 1'b0;
      end else begin
        state_d = S_DONE;
        res_d   = alu_res;
        zero_d  = (alu_res == '0);
      end
    end
  end

  always_comb begin
    out_valid = (state_q == S_DONE);
    busy      = FAST_SHIFT ? 1'b0 : (state_q == S_SHIFT);
    in_ready  = rst_n && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  end

  assign result = res_q;
  assign zero   = zero_q;
  assign lt     = lt_q;
  assign ltu    = ltu_q;

endmodule

// File: tb/tb_alu_iter_unit.sv
// Directed bench for alu_iter_unit: hand-computed vectors, latency, backpressure, reset abort.
module tb_alu_iter_unit;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  alu_con;
  logic [31:0] op_a, op_b, result;
  logic        zero, lt, ltu, busy;
  int n_chk = 0, n_pass = 0;
  int lat, bcnt;

  alu_iter_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_con(alu_con), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .lt(lt), .ltu(ltu), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Issue one op from IDLE with out_ready high; returns at the negedge where out_valid is seen.
  task automatic issue(input logic [3:0] con, input logic [31:0] a, input logic [31:0] b,
                       output int l, output int bc);
    @(negedge clk);
    alu_con = con; op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b1;
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'hDEAD_BEEF;
    l = 1; bc = 0;
    while (!out_valid && l < 100) begin
      if (busy) bc++;
      @(negedge clk);
      l++;
    end
    if (l >= 100) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_con = 4'h0; op_a = '0; op_b = '0;
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
    chk("rst_result",    result,             32'd0);
    chk("rst_flags",     {28'b0, zero, lt, ltu, busy}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    issue(4'b0000, 32'hFFFF_FFFF, 32'd1, lat, bcnt);
    chk("add_lat",    lat,    32'd1);
    chk("add_result", result, 32'h0000_0000);
    chk("add_flags",  {29'b0, zero, lt, ltu}, 32'b110);

    issue(4'b0001, 32'd5, 32'd7, lat, bcnt);
    chk("sub_result", result, 32'hFFFF_FFFE);
    chk("sub_flags",  {29'b0, zero, lt, ltu}, 32'b011);

    issue(4'b0111, 32'h8000_0000, 32'h0000_0024, lat, bcnt);
    chk("sra_result", result, 32'hF800_0000);
    chk("sra_lat",    lat,    FAST ? 32'd1 : 32'd5);
    chk("sra_busy",   bcnt,   FAST ? 32'd0 : 32'd4);
    chk("sra_flags",  {29'b0, zero, lt, ltu}, 32'b010);

    issue(4'b0110, 32'h8000_0000, 32'h0000_0024, lat, bcnt);
    chk("srl_result", result, 32'h0800_0000);
    chk("srl_lat",    lat,    FAST ? 32'd1 : 32'd5);

    issue(4'b0101, 32'h0000_1234, 32'h0000_0020, lat, bcnt);
    chk("sll0_result", result, 32'h0000_1234);
    chk("sll0_lat",    lat,    32'd1);

    issue(4'b1100, 32'h1234, 32'h1234, lat, bcnt);
    chk("cmp_result", result, 32'd0);
    chk("cmp_zero",   {31'b0, zero}, 32'd1);

    issue(4'b1111, 32'd2, 32'd3, lat, bcnt);
    chk("undef_add", result, 32'd5);

    issue(4'b0010, 32'h0000_F0F0, 32'h0000_FF00, lat, bcnt);
    chk("xor", result, 32'h0000_0FF0);
    issue(4'b0011, 32'h0000_F0F0, 32'h0000_FF00, lat, bcnt);
    chk("or",  result, 32'h0000_FFF0);
    issue(4'b0100, 32'h0000_F0F0, 32'h0000_FF00, lat, bcnt);
    chk("and", result, 32'h0000_F000);
    issue(4'b1011, 32'd1, 32'hFFFF_FFFF, lat, bcnt);
    chk("sltu", result, 32'd1);

    issue(4'b0101, 32'd1, 32'd31, lat, bcnt);
    chk("sll31_result", result, 32'h8000_0000);
    chk("sll31_lat",    lat,    FAST ? 32'd1 : 32'd32);
    chk("sll31_busy",   bcnt,   FAST ? 32'd0 : 32'd31);

    // Backpressure: slt held for three cycles, then back-to-back accept.
    @(negedge clk);
    alu_con = 4'b1101; op_a = 32'hFFFF_FFFF; op_b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid",    {31'b0, out_valid}, 32'd1);
      chk("bp_result",   result,             32'd1);
      chk("bp_in_ready", {31'b0, in_ready},  32'd0);
      @(negedge clk);
    end
    alu_con = 4'b0000; op_a = 32'd10; op_b = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_valid",  {31'b0, out_valid}, 32'd1);
    chk("b2b_result", result,             32'd30);
    @(negedge clk);
    chk("b2b_drain",  {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a long shift aborts it without output.
    @(negedge clk);
    alu_con = 4'b0101; op_a = 32'd1; op_b = 32'd31; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_result", result, 32'd0);
    chk("rstmid_flags",  {27'b0, out_valid, zero, lt, ltu, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) bcnt++;
    end
    chk("rstmid_no_out", bcnt, 32'd0);
    issue(4'b0000, 32'd7, 32'd8, lat, bcnt);
    chk("post_rst_add", result, 32'd15);
    chk("post_rst_lat", lat,    32'd1);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
